// File: rtl/soric_dbus_xbar_if.sv
// Bus bundle between the core data ports and the SRAM banks of soric_dbus_xbar.
// The master modport is the environment side (cores + SRAMs); the slave modport is the crossbar.
interface soric_dbus_xbar_if #(
    parameter int NCORE       = 2,
    parameter int NSRAM       = 4,
    parameter int D_ADDR_W    = 14,
    parameter int SRAM_ADDR_W = 11
);
    logic [NCORE-1:0]                   m_req_i;
    logic [NCORE*D_ADDR_W-1:0]          m_addr_i;
    logic [NCORE-1:0]                   m_we_i;
    logic [NCORE*4-1:0]                 m_be_i;
    logic [NCORE*32-1:0]                m_wdata_i;
    logic [NCORE-1:0]                   m_gnt_o;
    logic [NCORE-1:0]                   m_rvalid_o;
    logic [NCORE*32-1:0]                m_rdata_o;

    logic [NSRAM-1:0]                   s_csb_o;
    logic [NSRAM-1:0]                   s_web_o;
    logic [NSRAM*4-1:0]                 s_wmask_o;
    logic [NSRAM*(SRAM_ADDR_W-2)-1:0]   s_addr_o;
    logic [NSRAM*32-1:0]                s_wdata_o;
    logic [NSRAM*32-1:0]                s_rdata_i;

    modport master (
        output m_req_i, m_addr_i, m_we_i, m_be_i, m_wdata_i,
        input  m_gnt_o, m_rvalid_o, m_rdata_o,
        input  s_csb_o, s_web_o, s_wmask_o, s_addr_o, s_wdata_o,
        output s_rdata_i
    );

    modport slave (
        input  m_req_i, m_addr_i, m_we_i, m_be_i, m_wdata_i,
        output m_gnt_o, m_rvalid_o, m_rdata_o,
        output s_csb_o, s_web_o, s_wmask_o, s_addr_o, s_wdata_o,
        input  s_rdata_i
    );
endinterface

// File: rtl/soric_dbus_xbar.sv
// Core-to-SRAM data crossbar: address decode, per-bank round-robin arbitration,
// SRAM port drive and one-cycle read-data return to the requesting core.
module soric_dbus_xbar #(
    parameter int NCORE       = 2,
    parameter int NSRAM       = 4,
    parameter int D_ADDR_W    = 14,
    parameter int SRAM_ADDR_W = 11,
    parameter int BANK_W      = $clog2(NSRAM)
) (
    input logic              clk_i,
    input logic              rst_ni,
    soric_dbus_xbar_if.slave bus
);

    localparam int M_W    = (NCORE > 1) ? $clog2(NCORE) : 1;
    localparam int WA_W   = SRAM_ADDR_W - 2;
    localparam int HI_LSB = SRAM_ADDR_W + BANK_W;

    logic [NCORE-1:0]    req_act;
    logic [NCORE-1:0]    req_oor;
    logic [NCORE-1:0]    req_hit;
    logic [NCORE-1:0]    gnt;
    logic [D_ADDR_W-1:0] m_addr  [NCORE];
    logic [3:0]          m_be    [NCORE];
    logic [31:0]         m_wdata [NCORE];
    logic [BANK_W-1:0]   m_bank  [NCORE];
    logic [31:0]         s_rdata [NSRAM];

    logic [M_W-1:0]      last_q   [NSRAM];
    logic [NSRAM-1:0]    bank_vld;
    logic [M_W-1:0]      bank_sel [NSRAM];

    logic [NCORE-1:0]    rvalid_q;
    logic [NCORE-1:0]    we_q;
    logic [NCORE-1:0]    oor_q;
    logic [BANK_W-1:0]   bank_q [NCORE];

    // Requests are masked while reset is held so no grant or chip select leaks out.
    assign req_act = bus.m_req_i & {NCORE{rst_ni}};

    for (genvar m = 0; m < NCORE; m++) begin : g_dec
        logic unused_lsb;
        assign m_addr[m]  = bus.m_addr_i[m*D_ADDR_W +: D_ADDR_W];
        assign m_be[m]    = bus.m_be_i[m*4 +: 4];
        assign m_wdata[m] = bus.m_wdata_i[m*32 +: 32];
        assign m_bank[m]  = m_addr[m][SRAM_ADDR_W +: BANK_W];
        assign req_oor[m] = req_act[m] & (|m_addr[m][D_ADDR_W-1:HI_LSB]);
        assign req_hit[m] = req_act[m] & ~(|m_addr[m][D_ADDR_W-1:HI_LSB]);
        assign unused_lsb = ^m_addr[m][1:0];
    end

    for (genvar b = 0; b < NSRAM; b++) begin : g_rdata
        assign s_rdata[b] = bus.s_rdata_i[b*32 +: 32];
    end

    // Rank 1 is the master right after last[b]; the lowest requesting rank wins.
    always_comb begin
        int lst;
        int rank;
        int best;
        lst      = 0;
        rank     = 0;
        best     = 0;
        bank_vld = '0;
        for (int b = 0; b < NSRAM; b++) begin
            bank_sel[b] = '0;
            lst         = int'(last_q[b]);
            best        = NCORE + 1;
            for (int m = 0; m < NCORE; m++) begin
                rank = (m > lst) ? (m - lst) : (m + NCORE - lst);
                if (req_hit[m] && (m_bank[m] == BANK_W'(b)) && (rank < best)) begin
                    best        = rank;
                    bank_vld[b] = 1'b1;
                    bank_sel[b] = M_W'(m);
                end
            end
        end
    end

    always_comb begin
        gnt = '0;
        for (int m = 0; m < NCORE; m++) begin
            gnt[m] = req_oor[m]
                   | (req_hit[m] & bank_vld[m_bank[m]] & (bank_sel[m_bank[m]] == M_W'(m)));
        end
    end

    assign bus.m_gnt_o = gnt;

    always_comb begin
        bus.s_csb_o   = '1;
        bus.s_web_o   = '1;
        bus.s_wmask_o = '0;
        bus.s_addr_o  = '0;
        bus.s_wdata_o = '0;
        for (int b = 0; b < NSRAM; b++) begin
            if (bank_vld[b]) begin
                bus.s_csb_o[b]                 = 1'b0;
                bus.s_web_o[b]                 = ~bus.m_we_i[bank_sel[b]];
                bus.s_wmask_o[b*4 +: 4]        = m_be[bank_sel[b]];
                bus.s_addr_o[b*WA_W +: WA_W]   = m_addr[bank_sel[b]][SRAM_ADDR_W-1:2];
                bus.s_wdata_o[b*32 +: 32]      = m_wdata[bank_sel[b]];
            end
        end
    end

    // After reset last[] points at the highest master so master 0 wins first.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int b = 0; b < NSRAM; b++) begin
                last_q[b] <= M_W'(NCORE - 1);
            end
        end else begin
            for (int b = 0; b < NSRAM; b++) begin
                if (bank_vld[b]) begin
                    last_q[b] <= bank_sel[b];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid_q <= '0;
            we_q     <= '0;
            oor_q    <= '0;
            for (int m = 0; m < NCORE; m++) begin
                bank_q[m] <= '0;
            end
        end else begin
            rvalid_q <= gnt;
            for (int m = 0; m < NCORE; m++) begin
                if (gnt[m]) begin
                    we_q[m]   <= bus.m_we_i[m];
                    oor_q[m]  <= req_oor[m];
                    bank_q[m] <= m_bank[m];
                end
            end
        end
    end

    assign bus.m_rvalid_o = rvalid_q;

    // SRAM dout holds until the bank's next access, so it is safe to pass through unregistered.
    always_comb begin
        bus.m_rdata_o = '0;
        for (int m = 0; m < NCORE; m++) begin
            if (rvalid_q[m] && !we_q[m] && !oor_q[m]) begin
                bus.m_rdata_o[m*32 +: 32] = s_rdata[bank_q[m]];
            end
        end
    end

endmodule

// File: doc/soric_dbus_xbar.md
# soric_dbus_xbar

Data-bus crossbar between the NCORE core data ports (req/gnt/rvalid protocol) and the read-write port 0 of the NSRAM 2 kB SRAM banks. It decodes each core address to a bank and arbitrates per bank with round-robin priority. It drives the SRAM active-low chip-select, write-enable, mask, address and data, and routes one-cycle-latency read data back to the requesting core.

## Interface
- NCORE, 2, number of masters
- NSRAM, 4, number of SRAM banks (power of two)
- D_ADDR_W, 14, master byte-address width
- SRAM_ADDR_W, 11, byte-address width inside one bank (2 kB)
- BANK_W, $clog2(NSRAM), bank-select width
- clk_i  in  1  single clock, all state on rising edge
- rst_ni  in  1  reset; asynchronous, active-low
- m_req_i  in  NCORE  request per master
- m_addr_i  in  NCORE*D_ADDR_W  byte address, master m at [m*D_ADDR_W +: D_ADDR_W]
- m_we_i  in  NCORE  1 = write
- m_be_i  in  NCORE*4  byte enables
- m_wdata_i  in  NCORE*32  write data
- m_gnt_o  out  NCORE  grant, same cycle as accepted req
- m_rvalid_o  out  NCORE  response valid
- m_rdata_o  out  NCORE*32  response data
- s_csb_o  out  NSRAM  chip select, active-low
- s_web_o  out  NSRAM  write enable, active-low (0 = write)
- s_wmask_o  out  NSRAM*4  byte write mask
- s_addr_o  out  NSRAM*(SRAM_ADDR_W-2)  word address = addr[SRAM_ADDR_W-1:2]
- s_wdata_o  out  NSRAM*32  write data
- s_rdata_i  in  NSRAM*32  SRAM dout, valid the cycle after access

## Operation
- Decode: bank = addr[SRAM_ADDR_W +: BANK_W]; out-of-range when any bit addr[D_ADDR_W-1 : SRAM_ADDR_W+BANK_W] is 1 (addr >= 0x2000 at defaults).
- Per bank, register last[b] (master index). Among masters requesting bank b, grant the first index cyclically after last[b]; update last[b] on every grant. One grant per bank per cycle; different banks are granted in parallel.
- Granted master drives bank b: s_csb_o[b]=0, s_web_o[b]=~we, s_wmask_o=be, s_addr_o, s_wdata_o. Ungranted banks: csb=1, web=1, other outputs 0.
- Out-of-range requests are granted immediately without arbitration or SRAM access. The response is rvalid=1 with rdata=0.
- Response registers per master: rvalid_q, bank_q, we_q, oor_q, all loaded on grant.
- Next cycle: m_rvalid_o=rvalid_q and m_rdata_o = (we_q|oor_q) ? 0 : s_rdata_i[bank_q].
- Ungranted requests remain pending; the master holds req/addr/we/be/wdata until gnt.
- Reset asserted (including mid-transaction): m_gnt_o=0, m_rvalid_o=0, m_rdata_o=0, s_csb_o all 1, s_web_o all 1, last[b]=NCORE-1 (master 0 wins first). An in-flight response is dropped.

## Timing
- gnt is combinational from req/addr/last in the same cycle (cycle N). The SRAM samples on the N→N+1 edge.
- rvalid and rdata arrive in cycle N+1: latency exactly 1 for hits, writes and out-of-range.
- Back-to-back: a master granted in N may be granted again in N+1. The response for N and the grant for N+1 coincide, giving full throughput per master.
- Contention: two masters on one bank alternate grants every cycle. Worst-case wait is NCORE-1 cycles.
- rdata is not registered in the block. The SRAM dout holds until the next access to that bank, so reuse of a bank in N+1 does not corrupt the N+1 response.
- Reset deassertion: the first grant can occur in the first cycle with rst_ni=1.

## Test plan
- Single read: m0 reads 0x0804 (bank1, word 1) with SRAM model holding 0xDEADBEEF → gnt in N; s_csb_o=4'b1101, s_addr_o[bank1]=1; N+1 m_rvalid_o[0]=1, m_rdata_o=0xDEADBEEF.
- Write mask: m1 writes 0x12345678 be=4'b0011 to 0x1000 → bank2 csb=0, web=0, wmask=0011; N+1 rvalid[1]=1, rdata=0; readback gives 0x????5678 with the upper bytes unchanged.
- Contention: m0 and m1 both continuously read bank0 after reset → grants m0,m1,m0,m1…; each master gets rvalid every other cycle with the correct data.
- Parallel banks: m0→0x0000, m1→0x1800 in the same cycle → both granted in N, csb=4'b0110, both rvalid in N+1.
- Out-of-range: m0 reads 0x2000 → gnt in N, all csb=1, N+1 rvalid=1, rdata=0.
- Reset mid-op: rst_ni low in cycle N+1 after a grant → rvalid=0 immediately (async); after release, the first contended bank grants m0.
